c17_bist_ctrl: RTL and testbench

//  Built-in self-test sequencer for the extracted c17 NAND2X1 netlist. It applies all 32 input

---
 rtl/c17_bist_ctrl.sv | 163 ++++++++++++++++
 tb/tb_c17_bist_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/c17_bist_ctrl.sv
// c17_bist_ctrl: built-in self-test sequencer for the extracted c17 NAND2X1 netlist.
// Walks all 32 input vectors, holds each for SETTLE_CYCLES, samples O22/O23 and compares
// them against an internal golden c17 model. Reports pass/fail, a saturating error count
// and the index of the first failing vector.
module c17_bist_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_CNT_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 dut_O22,
    input  logic                 dut_O23,
    output logic                 dut_I1,
    output logic                 dut_I2,
    output logic                 dut_I3,
    output logic                 dut_I6,
    output logic                 dut_I7,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [4:0]           first_fail_vec,
    output logic                 first_fail_valid
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCheck
    } state_e;

    state_e                 state_q, state_d;
    logic [4:0]             p_q, p_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ERR_CNT_W-1:0]   err_q, err_d;
    logic [4:0]             ffvec_q, ffvec_d;
    logic                   ffv_q, ffv_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic [4:0]             drv_q, drv_d;

    logic n10, n11, n16, n19;
    logic gold_o22, gold_o23;
    logic mismatch;

    // Golden c17 model evaluated from the current vector register
    always_comb begin
        n10      = ~(p_q[4] & p_q[2]);
        n11      = ~(p_q[2] & p_q[1]);
        n16      = ~(p_q[3] & n11);
        n19      = ~(n11 & p_q[0]);
        gold_o22 = ~(n10 & n16);
        gold_o23 = ~(n16 & n19);
        mismatch = (dut_O22 != gold_o22) || (dut_O23 != gold_o23);
    end

    // Next-state logic: sequencing, comparison and result bookkeeping
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ffvec_d = ffvec_q;
        ffv_d   = ffv_q;
        done_d  = done_q;
        pass_d  = pass_q;

        case (state_q)
            StIdle: begin
                // abort is meaningless while idle, so start always wins here
                if (start) begin
                    state_d = StSettle;
                    p_d     = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    ffv_d   = 1'b0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            StSettle: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    if (mismatch) begin
                        if (err_q != '1) begin
                            err_d = err_q + ERR_CNT_W'(1);
                        end
                        if (!ffv_q) begin
                            ffvec_d = p_q;
                            ffv_d   = 1'b1;
                        end
                    end
                    if (p_q == 5'd31) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        // Uses err_d so the last vector's result is included
                        pass_d  = (err_d == '0);
                    end else begin
                        p_d     = p_q + 5'd1;
                        cnt_d   = '0;
                        state_d = StSettle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Netlist inputs come straight from a register; forced to zero whenever idle
        drv_d = (state_d == StIdle) ? 5'd0 : p_d;
    end

    // State register with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            p_q     <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ffvec_q <= '0;
            ffv_q   <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            drv_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ffvec_q <= ffvec_d;
            ffv_q   <= ffv_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            drv_q   <= drv_d;
        end
    end

    assign {dut_I1, dut_I2, dut_I3, dut_I6, dut_I7} = drv_q;
    assign busy             = (state_q != StIdle);
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_vec   = ffvec_q;
    assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// tb_c17_bist_ctrl: self-checking bench for c17_bist_ctrl with a behavioural c17 netlist,
// output fault injection and a result scoreboard.
module tb_c17_bist_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic abort;
    logic force22;
    logic force23;

    always #5 clk = ~clk;

    // Main instance, default parameters
    logic       i1_m, i2_m, i3_m, i6_m, i7_m;
    logic       o22_m, o23_m;
    logic       busy_m, done_m, pass_m, ffv_m;
    logic [5:0] err_m;
    logic [4:0] ffvec_m;
    logic [4:0] vec_m;
    logic [1:0] ref_m;

    // Saturation instance, 3-bit error counter, O23 stuck at 1
    logic       i1_s, i2_s, i3_s, i6_s, i7_s;
    logic       o22_s;
    logic       busy_s, done_s, pass_s, ffv_s;
    logic [2:0] err_s;
    logic [4:0] ffvec_s;
    logic [4:0] vec_s;
    logic [1:0] ref_s;

    // Sum-of-products form of c17; returns {O22, O23}
    function automatic logic [1:0] c17_ref(input logic [4:0] v);
        logic a1, a2, a3, a6, a7, o22, o23;
        {a1, a2, a3, a6, a7} = v;
        o22 = (a1 & a3) | (a2 & ~(a3 & a6));
        o23 = ~(a3 & a6) & (a2 | a7);
        return {o22, o23};
    endfunction

    assign vec_m = {i1_m, i2_m, i3_m, i6_m, i7_m};
    assign ref_m = c17_ref(vec_m);
    assign o22_m = force22 ? 1'b0 : ref_m[1];
    assign o23_m = force23 ? 1'b1 : ref_m[0];

    assign vec_s = {i1_s, i2_s, i3_s, i6_s, i7_s};
    assign ref_s = c17_ref(vec_s);
    assign o22_s = ref_s[1];

    c17_bist_ctrl u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .dut_O22          (o22_m),
        .dut_O23          (o23_m),
        .dut_I1           (i1_m),
        .dut_I2           (i2_m),
        .dut_I3           (i3_m),
        .dut_I6           (i6_m),
        .dut_I7           (i7_m),
        .busy             (busy_m),
        .done             (done_m),
        .pass             (pass_m),
        .err_count        (err_m),
        .first_fail_vec   (ffvec_m),
        .first_fail_valid (ffv_m)
    );

    c17_bist_ctrl #(
        .SETTLE_CYCLES (2),
        .ERR_CNT_W     (3)
    ) u_dut_sat (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .dut_O22          (o22_s),
        .dut_O23          (1'b1),
        .dut_I1           (i1_s),
        .dut_I2           (i2_s),
        .dut_I3           (i3_s),
        .dut_I6           (i6_s),
        .dut_I7           (i7_s),
        .busy             (busy_s),
        .done             (done_s),
        .pass             (pass_s),
        .err_count        (err_s),
        .first_fail_vec   (ffvec_s),
        .first_fail_valid (ffv_s)
    );

    typedef struct packed {
        logic       pass;
        logic [5:0] err;
        logic       ffv;
        logic [4:0] ffvec;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic p, input logic [5:0] e, input logic v, input logic [4:0] f);
        exp_t x;
        x.pass  = p;
        x.err   = e;
        x.ffv   = v;
        x.ffvec = f;
        sb_q.push_back(x);
    endtask

    // Starts a run and follows it to completion; returns busy length in cycles
    task automatic do_run(input string tag, input bit with_abort, input int mid_start_at,
                          output int len);
        int k;
        @(posedge clk); #1;
        start = 1'b1;
        abort = with_abort;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check_eq({tag, "/busy_at_start"}, busy_m, 1);
        k = 0;
        while (busy_m && k < 300) begin
            start = (k == mid_start_at);
            @(posedge clk); #1;
            k++;
            if (busy_m && ((k - 1) % 3 == 0)) begin
                check_eq({tag, "/vector"}, vec_m, (k - 1) / 3);
            end
        end
        start = 1'b0;
        len   = k;
        check_eq({tag, "/busy_len"}, len, 96);
        check_eq({tag, "/inputs_idle"}, vec_m, 0);
    endtask

    // Pops the expected result of the run that just ended and compares it
    task automatic check_result(input string tag);
        exp_t e;
        check_eq({tag, "/sb_depth"}, sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq({tag, "/done"}, done_m, 1);
            check_eq({tag, "/pass"}, pass_m, e.pass);
            check_eq({tag, "/err_count"}, err_m, e.err);
            check_eq({tag, "/ffv"}, ffv_m, e.ffv);
            if (e.ffv) begin
                check_eq({tag, "/ffvec"}, ffvec_m, e.ffvec);
            end
        end
    endtask

    initial begin
        int len;
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        force22 = 1'b0;
        force23 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst/busy", busy_m, 0);
        check_eq("rst/done", done_m, 0);
        check_eq("rst/pass", pass_m, 0);
        check_eq("rst/err", err_m, 0);
        check_eq("rst/ffv", ffv_m, 0);
        check_eq("rst/inputs", vec_m, 0);
        rst_n = 1'b1;

        // Good netlist, with an ignored start pulse mid-run
        push_exp(1'b1, 6'd0, 1'b0, 5'd0);
        do_run("good", 1'b0, 50, len);
        check_result("good");
        repeat (5) @(posedge clk);
        #1;
        check_eq("good/done_hold", done_m, 1);
        check_eq("good/pass_hold", pass_m, 1);

        // O22 stuck at 0
        force22 = 1'b1;
        push_exp(1'b0, 6'd18, 1'b1, 5'd8);
        do_run("o22_sa0", 1'b0, -1, len);
        check_result("o22_sa0");
        force22 = 1'b0;

        // O23 stuck at 1; the 3-bit instance must saturate
        force23 = 1'b1;
        push_exp(1'b0, 6'd14, 1'b1, 5'd0);
        do_run("o23_sa1", 1'b0, -1, len);
        check_result("o23_sa1");
        check_eq("sat/done", done_s, 1);
        check_eq("sat/err_count", err_s, 7);
        check_eq("sat/pass", pass_s, 0);
        force23 = 1'b0;

        // Abort partway through a run
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        check_eq("abort/busy_before", busy_m, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_eq("abort/busy", busy_m, 0);
        check_eq("abort/done", done_m, 0);
        check_eq("abort/pass", pass_m, 0);
        check_eq("abort/inputs", vec_m, 0);
        check_eq("abort/err", err_m, 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort/stay_idle", busy_m, 0);

        // start and abort together while idle: start wins
        push_exp(1'b1, 6'd0, 1'b0, 5'd0);
        do_run("restart", 1'b1, -1, len);
        check_result("restart");

        // Reset mid-run clears everything without a clock edge
        force23 = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_eq("rstmid/ffv_before", ffv_m, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rstmid/busy", busy_m, 0);
        check_eq("rstmid/done", done_m, 0);
        check_eq("rstmid/pass", pass_m, 0);
        check_eq("rstmid/err", err_m, 0);
        check_eq("rstmid/ffv", ffv_m, 0);
        check_eq("rstmid/ffvec", ffvec_m, 0);
        check_eq("rstmid/inputs", vec_m, 0);
        force23 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rstmid/no_resume", busy_m, 0);
        push_exp(1'b1, 6'd0, 1'b0, 5'd0);
        do_run("after_rst", 1'b0, -1, len);
        check_result("after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
